// File: rtl/flash_page_buffer.sv
// Page staging buffer in front of the QSPI page-program controller.
// Gathers a byte stream into one flash page, launches a program cycle, then serves the bytes on request.
module flash_page_buffer #(
  parameter int                PAGE_BYTES = 256,
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] START_ADDR = 32'h00001000
) (
  input  logic              system_clk,
  input  logic              system_reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  output logic              pp_key,
  output logic [ADDR_W-1:0] pp_addr,
  output logic [7:0]        pp_num,
  output logic [7:0]        pp_data,
  input  logic              pp_byte_req,
  input  logic              pp_done,
  output logic              busy,
  output logic [15:0]       page_count
);

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_PROG   = 2'd2,
    ST_NEXT   = 2'd3
  } state_t;

  localparam logic [7:0]        LAST_IDX  = 8'(PAGE_BYTES - 1);
  localparam logic [ADDR_W-1:0] PAGE_STEP = ADDR_W'(PAGE_BYTES);

  logic [7:0]        mem_r [0:255];
  state_t            state_r;
  state_t            state_s;
  logic [7:0]        wr_ptr_r;
  logic [7:0]        rd_ptr_r;
  logic [7:0]        num_s;
  logic [ADDR_W-1:0] cur_addr_r;
  logic              wr_en_s;
  logic              launch_s;
  logic              rd_en_s;

  assign wr_en_s  = (state_r == ST_FILL) && in_valid && in_ready;
  assign launch_s = (state_r == ST_FILL) && (state_s == ST_LAUNCH);
  // The read port also runs on the edge that enters LAUNCH so byte 0 is on pp_data during the launch pulse.
  assign rd_en_s  = launch_s || (state_r == ST_LAUNCH) || (state_r == ST_PROG);

  // Next-state and launch byte-count decode.
  always_comb begin
    state_s = state_r;
    num_s   = pp_num;
    case (state_r)
      ST_FILL: begin
        if (wr_en_s && (wr_ptr_r == LAST_IDX)) begin
          state_s = ST_LAUNCH;
          num_s   = LAST_IDX;
        end else if (flush && wr_en_s) begin
          state_s = ST_LAUNCH;
          num_s   = wr_ptr_r;
        end else if (flush && (wr_ptr_r != 8'd0)) begin
          state_s = ST_LAUNCH;
          num_s   = wr_ptr_r - 8'd1;
        end else begin
          state_s = ST_FILL;
        end
      end
      ST_LAUNCH: state_s = ST_PROG;
      ST_PROG: begin
        if (pp_done) begin
          state_s = ST_NEXT;
        end else begin
          state_s = ST_PROG;
        end
      end
      ST_NEXT: state_s = ST_FILL;
      default: state_s = ST_FILL;
    endcase
  end

  // FSM state register.
  always_ff @(posedge system_clk or posedge system_reset) begin
    if (system_reset) begin
      state_r <= ST_FILL;
    end else begin
      state_r <= state_s;
    end
  end

  // Page RAM write port; contents are deliberately not reset.
  always_ff @(posedge system_clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= in_data;
    end
  end

  // Registered RAM read, write-first so a single-byte page launches with its fresh byte.
  always_ff @(posedge system_clk or posedge system_reset) begin
    if (system_reset) begin
      pp_data <= 8'd0;
    end else if (rd_en_s) begin
      if (wr_en_s && (wr_ptr_r == rd_ptr_r)) begin
        pp_data <= in_data;
      end else begin
        pp_data <= mem_r[rd_ptr_r];
      end
    end else begin
      pp_data <= pp_data;
    end
  end

  // Buffer pointers, flash address and completed-page counter.
  always_ff @(posedge system_clk or posedge system_reset) begin
    if (system_reset) begin
      wr_ptr_r   <= 8'd0;
      rd_ptr_r   <= 8'd0;
      cur_addr_r <= START_ADDR;
      page_count <= 16'd0;
    end else begin
      if (state_r == ST_NEXT) begin
        wr_ptr_r <= 8'd0;
      end else if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + 8'd1;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      // A req coinciding with pp_done is dropped because state_s has already left PROG.
      if ((state_r == ST_PROG) && (state_s == ST_PROG) && pp_byte_req && (rd_ptr_r != pp_num)) begin
        rd_ptr_r <= rd_ptr_r + 8'd1;
      end else if (state_r != ST_PROG) begin
        rd_ptr_r <= 8'd0;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      if (state_r == ST_NEXT) begin
        cur_addr_r <= cur_addr_r + PAGE_STEP;
        page_count <= page_count + 16'd1;
      end else begin
        cur_addr_r <= cur_addr_r;
        page_count <= page_count;
      end
    end
  end

  // Registered handshake and launch outputs, decoded from the upcoming state.
  always_ff @(posedge system_clk or posedge system_reset) begin
    if (system_reset) begin
      in_ready <= 1'b0;
      pp_key   <= 1'b0;
      busy     <= 1'b0;
      pp_num   <= 8'd0;
      pp_addr  <= START_ADDR;
    end else begin
      in_ready <= (state_s == ST_FILL);
      busy     <= (state_s != ST_FILL);
      pp_key   <= launch_s;
      if (launch_s) begin
        pp_num  <= num_s;
        pp_addr <= cur_addr_r;
      end else begin
        pp_num  <= pp_num;
        pp_addr <= pp_addr;
      end
    end
  end

endmodule

// File: tb/tb_flash_page_buffer.sv
// Randomised bench for flash_page_buffer: a page-level model predicts every output each cycle,
// and literal expectations pin the model for the directed scenarios.
module tb_flash_page_buffer;

  localparam int          PB    = 256;
  localparam logic [31:0] START = 32'h00001000;
  localparam int PH_FILL = 0, PH_LAUNCH = 1, PH_PROG = 2, PH_NEXT = 3;

  logic        system_clk = 1'b0;
  logic        system_reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic        pp_key;
  logic [31:0] pp_addr;
  logic [7:0]  pp_num;
  logic [7:0]  pp_data;
  logic        pp_byte_req;
  logic        pp_done;
  logic        busy;
  logic [15:0] page_count;

  flash_page_buffer #(.PAGE_BYTES(PB), .ADDR_W(32), .START_ADDR(START)) dut (
    .system_clk(system_clk), .system_reset(system_reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .pp_key(pp_key), .pp_addr(pp_addr), .pp_num(pp_num), .pp_data(pp_data),
    .pp_byte_req(pp_byte_req), .pp_done(pp_done), .busy(busy), .page_count(page_count)
  );

  always #10 system_clk = ~system_clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Page-level model: which phase the page is in, the bytes it holds, how many reqs were taken.
  int          m_phase;
  bit          m_rdy, m_key, m_busy, m_acc;
  byte unsigned m_buf[$];
  logic [31:0] m_addr, m_pp_addr;
  logic [7:0]  m_num, m_data;
  logic [15:0] m_pages;
  int          m_reqs;
  bit          chk_en = 1'b0;

  task automatic model_reset();
    m_phase = PH_FILL; m_rdy = 1'b0; m_key = 1'b0; m_busy = 1'b0; m_acc = 1'b0;
    m_buf.delete();
    m_addr = START; m_pp_addr = START; m_num = 8'd0; m_data = 8'd0;
    m_pages = 16'd0; m_reqs = 0;
  endtask

  task automatic model_edge(input bit iv, input logic [7:0] d, input bit fl, input bit rq, input bit dn);
    int idx;
    m_acc = 1'b0;
    m_key = 1'b0;
    case (m_phase)
      PH_FILL: begin
        if (iv && m_rdy) begin
          m_buf.push_back(d);
          m_acc = 1'b1;
        end
        if ((m_acc && m_buf.size() == PB) || (fl && m_buf.size() > 0)) begin
          m_phase = PH_LAUNCH; m_key = 1'b1; m_num = 8'(m_buf.size() - 1);
          m_pp_addr = m_addr; m_reqs = 0; m_rdy = 1'b0; m_busy = 1'b1; m_data = m_buf[0];
        end else begin
          m_rdy = 1'b1;
        end
      end
      PH_LAUNCH: begin
        m_phase = PH_PROG;
        m_data  = m_buf[0];
      end
      PH_PROG: begin
        // data shown now reflects reqs taken up to the previous cycle (2-cycle req-to-data latency)
        idx = (m_reqs > int'(m_num)) ? int'(m_num) : m_reqs;
        m_data = m_buf[idx];
        if (dn) m_phase = PH_NEXT;
        else if (rq) m_reqs++;
      end
      default: begin
        m_phase = PH_FILL; m_addr = m_addr + 32'(PB); m_pages = m_pages + 16'd1;
        m_buf.delete(); m_rdy = 1'b1; m_busy = 1'b0;
      end
    endcase
  endtask

  task automatic step(input bit iv, input logic [7:0] d, input bit fl, input bit rq, input bit dn);
    in_valid = iv; in_data = d; flush = fl; pp_byte_req = rq; pp_done = dn;
    @(posedge system_clk);
    model_edge(iv, d, fl, rq, dn);
    #2;
  endtask

  always @(negedge system_clk) begin
    if (chk_en && !system_reset) begin
      check("in_ready", in_ready, m_rdy);
      check("pp_key", pp_key, m_key);
      check("busy", busy, m_busy);
      check("page_count", page_count, m_pages);
      check("pp_addr", pp_addr, m_pp_addr);
      check("pp_num", pp_num, m_num);
      if (m_phase == PH_LAUNCH || m_phase == PH_PROG) check("pp_data", pp_data, m_data);
    end
  end

  // Push n accepted bytes; optionally raise flush together with the last accepted write.
  task automatic fill_bytes(input int n, input bit rnd, input logic [7:0] base, input bit flush_last, input int pvalid);
    int got = 0;
    int guard = 0;
    bit iv;
    logic [7:0] d;
    while (got < n && guard < 20 * n + 50) begin
      iv = ($urandom_range(99) < pvalid);
      d  = rnd ? 8'($urandom) : base + 8'(got);
      step(iv, d, flush_last && iv && m_rdy && (got == n - 1), ($urandom_range(15) == 0),
           ($urandom_range(31) == 0));
      if (m_acc) got++;
      guard++;
    end
    if (got < n) check("fill_timeout", got, n);
  endtask

  // Drain a launched page: one req per byte spaced 3..5 cycles, then pp_done.
  task automatic serve(input bit hold_valid, output logic [7:0] last);
    int reqs;
    check("launch_key", pp_key, 1'b1);
    reqs = int'(m_num) + 1;
    step(hold_valid, 8'($urandom), 1'b0, 1'($urandom_range(1)), 1'b0);
    for (int k = 0; k < reqs; k++) begin
      step(hold_valid, 8'($urandom), 1'b0, 1'b1, 1'b0);
      repeat ($urandom_range(4, 2)) step(hold_valid, 8'($urandom), ($urandom_range(3) == 0), 1'b0, 1'b0);
    end
    last = pp_data;
    step(hold_valid, 8'($urandom), 1'b0, 1'b0, 1'b1);
    step(hold_valid, 8'($urandom), 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] last;
    int n;
    system_reset = 1'b1;
    in_valid = 1'b0; in_data = 8'd0; flush = 1'b0; pp_byte_req = 1'b0; pp_done = 1'b0;
    model_reset();
    repeat (3) @(posedge system_clk);
    #2;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_pp_addr", pp_addr, 32'h00001000);
    check("rst_page_count", page_count, 16'd0);
    system_reset = 1'b0;
    chk_en = 1'b1;

    // full page 0x10+i
    fill_bytes(PB, 1'b0, 8'h10, 1'b0, 70);
    check("t1_pp_addr", pp_addr, 32'h00001000);
    check("t1_pp_num", pp_num, 8'd255);
    check("t1_first_byte", pp_data, 8'h10);
    serve(1'b0, last);
    check("t1_last_byte", last, 8'h0F);
    check("t2_page_count", page_count, 16'd1);
    check("t2_busy", busy, 1'b0);

    // 10 bytes then a separate flush
    fill_bytes(10, 1'b0, 8'hA0, 1'b0, 80);
    step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    check("t3_pp_addr", pp_addr, 32'h00001100);
    check("t3_pp_num", pp_num, 8'd9);
    serve(1'b0, last);
    check("t3_last_byte", last, 8'hA9);

    // empty flush ignored, then flush on the 5th write
    step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    check("t4_no_key", pp_key, 1'b0);
    check("t4_not_busy", busy, 1'b0);
    fill_bytes(5, 1'b1, 8'h00, 1'b1, 100);
    check("t4_pp_num", pp_num, 8'd4);
    check("t4_pp_addr", pp_addr, 32'h00001200);
    serve(1'b0, last);

    // in_valid held through PROG; the following page must still need a full PB bytes
    fill_bytes(20, 1'b1, 8'h00, 1'b1, 60);
    serve(1'b1, last);
    fill_bytes(PB, 1'b1, 8'h00, 1'b0, 90);
    check("t5_pp_num", pp_num, 8'd255);
    serve(1'b0, last);

    // random page sizes and flush styles
    for (int p = 0; p < 3; p++) begin
      n = $urandom_range(1, PB);
      if (n == PB) begin
        fill_bytes(n, 1'b1, 8'h00, 1'b0, 75);
      end else if ($urandom_range(1) == 1) begin
        fill_bytes(n, 1'b1, 8'h00, 1'b1, 75);
      end else begin
        fill_bytes(n, 1'b1, 8'h00, 1'b0, 75);
        step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
      end
      serve(1'b0, last);
    end

    // reset in the middle of PROG
    fill_bytes(30, 1'b1, 8'h00, 1'b1, 90);
    step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    system_reset = 1'b1;
    in_valid = 1'b0; flush = 1'b0; pp_byte_req = 1'b0; pp_done = 1'b0;
    #1;
    check("t6_pp_key", pp_key, 1'b0);
    check("t6_busy", busy, 1'b0);
    check("t6_in_ready", in_ready, 1'b0);
    check("t6_pp_addr", pp_addr, 32'h00001000);
    check("t6_pp_num", pp_num, 8'd0);
    check("t6_pp_data", pp_data, 8'd0);
    check("t6_page_count", page_count, 16'd0);
    model_reset();
    repeat (2) @(posedge system_clk);
    #2;
    system_reset = 1'b0;
    fill_bytes(PB, 1'b1, 8'h00, 1'b0, 85);
    check("t6_launch_addr", pp_addr, 32'h00001000);
    check("t6_launch_num", pp_num, 8'd255);
    serve(1'b0, last);
    check("t6_page_count_after", page_count, 16'd1);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
